// File: rtl/systolic_pkg.sv
// Shared definitions for the exhaustive NOR-array sweeper: array size defaults,
// vector count and the controller state encoding.
package systolic_pkg;

  localparam int ROW_DEF    = 4;
  localparam int COLUMN_DEF = 8;
  localparam int NUM_VEC    = 1 << (ROW_DEF + COLUMN_DEF);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EMIT,
    FINISH
  } state_t;

endpackage

// File: rtl/systolic_sweep_packer.sv
// Collects sampled array results into 8-bit words, tracks the word address of
// the most recent sample and counts how many samples were 1.
module systolic_sweep_packer #(
  parameter int AW = 9,
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_sample,
  input  logic [2:0]    i_bit,
  input  logic [AW-1:0] i_word,
  input  logic          i_out,
  output logic [7:0]    o_data,
  output logic [AW-1:0] o_addr,
  output logic [CW-1:0] o_ones
);

  logic [7:0]    r_data;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_ones;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_data <= '0;
      r_addr <= '0;
      r_ones <= '0;
    end else if (i_sample) begin
      r_data[i_bit] <= i_out;
      r_addr        <= i_word;
      r_ones        <= r_ones + CW'(i_out);
    end
  end

  assign o_data = r_data;
  assign o_addr = r_addr;
  assign o_ones = r_ones;

endmodule

// File: rtl/systolic_sweep.sv
// Drives every row/column input combination into an external NOR array, samples
// its result after a settle delay and streams the results out as packed words.
module systolic_sweep
  import systolic_pkg::*;
#(
  parameter int ROW    = ROW_DEF,
  parameter int COLUMN = COLUMN_DEF,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ROW-1:0]          inRow,
  output logic [COLUMN-1:0]       inColumn,
  input  logic                    out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [7:0]              res_data,
  output logic [ROW+COLUMN-4:0]   res_addr,
  output logic [ROW+COLUMN:0]     ones_count,
  output state_t                  o_dbg_state
);

  localparam int          NB          = ROW + COLUMN;
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE - 1);

  state_t        r_state;
  state_t        w_next;
  logic [NB:0]   r_idx;
  logic [7:0]    r_settle;
  logic          w_clear;
  logic          w_sample;

  // Result handshake: a word transfers on a rising edge where res_valid and
  // res_ready are both high; once raised, res_valid and the word stay put
  // until that transfer happens.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = DRIVE;
      DRIVE:   if (r_settle == 8'd0) w_next = SAMPLE;
      SAMPLE:  w_next = (r_idx[2:0] == 3'd7) ? EMIT : DRIVE;
      // The carry into the extra idx bit appears exactly after the last vector.
      EMIT:    if (res_ready) w_next = r_idx[NB] ? FINISH : DRIVE;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_clear     = (r_state == IDLE) && start;
  assign w_sample    = (r_state == SAMPLE);
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == FINISH);
  assign res_valid   = (r_state == EMIT);
  assign inRow       = r_idx[ROW-1:0];
  assign inColumn    = r_idx[NB-1:ROW];
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_settle <= SETTLE_LOAD;
    end else begin
      r_state <= w_next;
      if (w_clear)
        r_idx <= '0;
      else if (w_sample)
        r_idx <= r_idx + 1'b1;
      // Reloads whenever not driving so every vector gets the full hold time.
      if (r_state == DRIVE)
        r_settle <= r_settle - 8'd1;
      else
        r_settle <= SETTLE_LOAD;
    end
  end

  systolic_sweep_packer #(
    .AW (NB - 3),
    .CW (NB + 1)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_sample (w_sample),
    .i_bit    (r_idx[2:0]),
    .i_word   (r_idx[NB-1:3]),
    .i_out    (out),
    .o_data   (res_data),
    .o_addr   (res_addr),
    .o_ones   (ones_count)
  );

endmodule
